// File: rtl/usb_rx_fifo.sv
// Byte FIFO between the USB-serial receive pipeline and the CPU input port.
// Optional almost_full output enabled by defining USB_RX_FIFO_ALMOST_FULL_EN.
module usb_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
`ifdef USB_RX_FIFO_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH = DEPTH - 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    input  logic             clr_ovf,
    output logic [LW-1:0]    level,
    output logic             overrun
`ifdef USB_RX_FIFO_ALMOST_FULL_EN
    ,
    output logic             almost_full
`endif
);

    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("usb_rx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic [LW-1:0]    count_next;
    logic             push;
    logic             pop;
    logic             ovf_event;

    // Handshake flags come from the registered count only; no out_ready -> in_ready path.
    always_comb begin
        in_ready  = (count != LW'(DEPTH));
        out_valid = (count != '0);
        out_data  = mem[rd_ptr];
        level     = count;
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
        ovf_event = in_valid & ~in_ready;
    end

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + LW'(1);
                2'b01:   count_next = count - LW'(1);
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
            // A new overrun event outranks a simultaneous clear.
            if (ovf_event) begin
                overrun <= 1'b1;
            end else if (clr_ovf) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

`ifdef USB_RX_FIFO_ALMOST_FULL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (int'(count_next) >= AF_THRESH);
        end
    end
`endif

endmodule

// File: tb/tb_usb_rx_fifo.sv
// Randomized scoreboard bench for usb_rx_fifo; also exercises almost_full
// when USB_RX_FIFO_ALMOST_FULL_EN is defined.
module tb_usb_rx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int AFT   = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             flush = 1'b0;
    logic             clr_ovf = 1'b0;
    logic [LW-1:0]    level;
    logic             overrun;
`ifdef USB_RX_FIFO_ALMOST_FULL_EN
    logic             almost_full;
`endif

    usb_rx_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
`ifdef USB_RX_FIFO_ALMOST_FULL_EN
        ,
        .AF_THRESH(AFT)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .flush(flush),
        .clr_ovf(clr_ovf),
        .level(level),
        .overrun(overrun)
`ifdef USB_RX_FIFO_ALMOST_FULL_EN
        ,
        .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_popped = 0;

    // Reference model state: expected byte stream, occupancy, flags.
    logic [WIDTH-1:0] sb[$];
    int               m_count = 0;
    int               m_ovr = 0;
    int               m_af = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Predictor: checks flags against the model, then applies this edge's rules.
    always @(negedge clk) begin
        if (rst) begin
            m_count = 0;
            m_ovr   = 0;
            m_af    = 0;
            sb.delete();
        end else begin
            chk("level", int'(level), m_count);
            chk("in_ready", int'(in_ready), int'(m_count != DEPTH));
            chk("out_valid", int'(out_valid), int'(m_count != 0));
            chk("overrun", int'(overrun), m_ovr);
`ifdef USB_RX_FIFO_ALMOST_FULL_EN
            chk("almost_full", int'(almost_full), m_af);
`endif
            if (in_valid && m_count == DEPTH) m_ovr = 1;
            else if (clr_ovf) m_ovr = 0;
            if (flush) begin
                m_count = 0;
                sb.delete();
            end else begin
                int p_in, p_out;
                p_in  = (in_valid && m_count != DEPTH) ? 1 : 0;
                p_out = (out_ready && m_count != 0) ? 1 : 0;
                if (p_in != 0) sb.push_back(in_data);
                m_count = m_count + p_in - p_out;
            end
            m_af = (m_count >= AFT) ? 1 : 0;
        end
    end

    // Monitor: whenever the DUT presents a byte, it must be the scoreboard head.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid) begin
            if (sb.size() == 0) begin
                chk("out_data_unexpected", int'(out_data), -1);
            end else begin
                chk("out_data", int'(out_data), int'(sb[0]));
                if (out_ready) begin
                    void'(sb.pop_front());
                    n_popped++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        cyc();
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        clr_ovf   = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        // Reset then idle
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        idle(2);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);

        // Single byte, 1-cycle latency
        drive(1'b1, 8'hA5, 1'b0);
        in_valid = 1'b0;
        chk("single_valid", int'(out_valid), 1);
        chk("single_data", int'(out_data), 'hA5);
        chk("single_level", int'(level), 1);
        drive(1'b0, 8'h00, 1'b1);
        out_ready = 1'b0;
        chk("single_empty", int'(out_valid), 0);
        idle(1);

        // Fill, overrun attempt, drain
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0);
        chk("full_level", int'(level), DEPTH);
        chk("full_in_ready", int'(in_ready), 0);
        drive(1'b1, 8'h10, 1'b0);
        in_valid = 1'b0;
        chk("ovf_set", int'(overrun), 1);
        chk("ovf_level", int'(level), DEPTH);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 8'h00, 1'b1);
        idle(1);
        chk("drained_level", int'(level), 0);

        // Wrap with concurrent push/pop at level 8
        for (int i = 0; i < 8; i++) drive(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b1, 8'($urandom), 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("wrap_level", int'(level), 8);

        // Flush priority at level 5, overrun still set from the fill test
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1);
        out_ready = 1'b0;
        chk("pre_flush_level", int'(level), 5);
        flush = 1'b1;
        drive(1'b1, 8'h77, 1'b1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("flush_level", int'(level), 0);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_ovf_kept", int'(overrun), 1);
        idle(2);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("ovf_cleared", int'(overrun), 0);

`ifdef USB_RX_FIFO_ALMOST_FULL_EN
        for (int i = 0; i < AFT - 1; i++) drive(1'b1, 8'($urandom), 1'b0);
        chk("af_below", int'(almost_full), 0);
        drive(1'b1, 8'($urandom), 1'b0);
        in_valid = 1'b0;
        chk("af_set", int'(almost_full), 1);
        drive(1'b0, 8'h00, 1'b1);
        out_ready = 1'b0;
        chk("af_clear", int'(almost_full), 0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            flush   = ($urandom_range(0, 39) == 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            if (i < 300) drive($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 40);
            else         drive($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 99) < 70);
        end
        idle(1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;

        // Async reset mid-burst at level 9
        for (int i = 0; i < 9; i++) drive(1'b1, 8'($urandom), 1'b0);
        chk("pre_rst_level", int'(level), 9);
        in_data = 8'hEE;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_level", int'(level), 0);
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_in_ready", int'(in_ready), 1);
        in_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        idle(2);

        // Short burst after reset to confirm recovery
        for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom), $urandom_range(0, 1) == 1);
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 8'h00, 1'b1);
        idle(2);
        chk("final_level", int'(level), 0);
        chk("bytes_seen_min", int'(n_popped > 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/usb_rx_fifo.md
Name: usb_rx_fifo

Overview:
Byte buffer between the USB-serial device's received-data pipeline and the boneless_core USB input port. It absorbs bursts from the host while the CPU firmware is busy, using valid/ready handshakes on both sides. It also gives the CPU a fill level and a sticky overrun flag for the case where the upstream source pushes while the FIFO is full.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- WIDTH, 8, data width in bits.
- LW, $clog2(DEPTH)+1, width of the level output; derived, not to be overridden.

Ports:
- clk  input  1  system clock (48 MHz domain).
- rst  input  1  asynchronous active-high reset.
- in_data  input  WIDTH  byte from the USB-serial receive pipeline.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept a byte this cycle.
- out_data  output  WIDTH  head-of-FIFO byte to the CPU.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  CPU consumes the head byte this cycle.
- flush  input  1  synchronous clear of FIFO contents.
- clr_ovf  input  1  clears the sticky overrun flag.
- level  output  LW  current number of stored bytes, 0..DEPTH.
- overrun  output  1  sticky flag: a push was attempted while the FIFO was full.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset state: wr_ptr=0, rd_ptr=0, count=0, overrun=0. Outputs: in_ready=1, out_valid=0, level=0. out_data is don't-care. Storage array is not reset.
- Push: happens when in_valid & in_ready at a rising edge. Byte is written to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: happens when out_valid & out_ready at a rising edge. rd_ptr increments modulo DEPTH.
- Pointers: log2(DEPTH) bits wide and wrap naturally. Fullness is tracked by a separate LW-bit count, not derived from the pointers.
- in_ready = (count != DEPTH). It depends on registered state only; there is no combinational path from out_ready. A full FIFO refuses a push even in a cycle where it pops.
- out_valid = (count != 0). out_data = mem[rd_ptr], read combinationally.
- Latency: a byte pushed into an empty FIFO appears on out_valid/out_data in the following cycle (1-cycle latency).
- Hold rule: while out_valid & !out_ready, out_data and out_valid stay stable.
- Push and pop in the same cycle (possible only when 0 < count < DEPTH): count is unchanged and both pointers advance.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. level = count.
- Overrun: set on any edge where in_valid & !in_ready. The data is dropped and the upstream stage holds or discards it per its own rules. overrun clears only on clr_ovf or rst. If clr_ovf and a new overrun event occur in the same cycle, the set wins.
- Flush: at the next edge, pointers and count go to 0. Flush has priority over push and pop in that cycle; a concurrent push is discarded and does not set overrun. overrun is not affected by flush.
- Reset asserted mid-transfer: all state clears immediately. Any byte in flight is lost; the upstream stage sees in_ready=1 after reset.

Optional Feature:
- Macro: USB_RX_FIFO_ALMOST_FULL_EN.
- When defined:
  - Adds parameter AF_THRESH (default DEPTH-4) and output almost_full (1 bit).
  - almost_full is registered, set when count >= AF_THRESH after the edge's update, and resets to 0.
  - Firmware uses it to poll and drain early.
- When undefined: neither the port nor the parameter exists, and the logic is identical otherwise.

Test Plan:
- Reset then idle: after rst deasserts, require in_ready=1, out_valid=0, level=0, overrun=0.
- Single byte: push 0xA5 into an empty FIFO with out_ready=0. Next cycle require out_valid=1, out_data=0xA5, level=1. Pulse out_ready; next cycle require out_valid=0, level=0.
- Fill and overrun: push 0x00..0x0F (DEPTH=16).
  - Require level=16 and in_ready=0.
  - Present 0x10 with in_valid=1: require overrun=1 next cycle and 0x10 not stored.
  - Drain 16 bytes: require the sequence 0x00..0x0F exactly.
- Wrap and concurrent: keep level at 8 with continuous simultaneous push/pop for 40 cycles. Require level constant at 8, pointers wrapping, and output order exactly matching input order.
- Flush priority: at level=5, assert flush together with in_valid (0x77) and out_ready. Next cycle require level=0, out_valid=0, overrun unchanged, and 0x77 never appears on out_data.
- Async reset mid-burst: assert rst between clock edges during a burst at level=9. Require level=0 and out_valid=0 immediately, without waiting for a clock edge. With USB_RX_FIFO_ALMOST_FULL_EN defined and AF_THRESH=12, require almost_full=1 after the 12th push and 0 after the following pop.
